// File: rtl/uart_register_port_pkg.sv
// Shared definitions for the UART register port: register indices,
// STATUS bit positions and the TX/RX state encodings.
package uart_register_port_pkg;

    // Register indices on the core's register bus
    localparam logic [6:0] REG_UART_TX     = 7'd0;
    localparam logic [6:0] REG_UART_RX     = 7'd1;
    localparam logic [6:0] REG_UART_STATUS = 7'd2;
    localparam logic [6:0] REG_UART_BAUD   = 7'd3;

    // STATUS register bit positions
    localparam int STATUS_TX_FULL     = 0;
    localparam int STATUS_TX_EMPTY    = 1;
    localparam int STATUS_RX_AVAIL    = 2;
    localparam int STATUS_RX_OVERRUN  = 3;
    localparam int STATUS_TX_BUSY     = 4;
    localparam int STATUS_FRAMING_ERR = 5;

    // Serializer / deserializer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_register_port_sync_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart; the head entry is visible without a pop so the
// bus can return it in the same access that removes it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop    = pop && !empty;
    // A push into a full FIFO still lands when a pop frees the slot this cycle
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; both pointers wrap modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_register_port.sv
// Memory-mapped 8N1 UART on the core register bus: TX/RX FIFOs, a STATUS
// register with sticky error flags and a programmable baud divisor
// (clocks per bit = BAUD_DIV + 1).
module uart_register_port
    import uart_register_port_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);

    // ---------------- bus-side registers ----------------
    logic [15:0] baud_div_reg;
    logic        overrun_reg;
    logic        framing_reg;
    logic [15:0] read_value_reg;
    logic [15:0] read_value_next;
    logic [15:0] status_word;

    // ---------------- FIFO interfaces ----------------
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;

    // ---------------- TX serializer ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;

    // ---------------- RX deserializer ----------------
    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic        rx_stop_sample;
    logic        set_overrun, set_framing;

    logic        write_status;

    // Bus decode. Only a pure read of RX_DATA pops, so store cycles that
    // happen to assert the read strobe never lose a byte.
    assign tx_push      = register_write && (register_index == REG_UART_TX);
    assign rx_pop       = register_read && !register_write && (register_index == REG_UART_RX);
    assign write_status = register_write && (register_index == REG_UART_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data (register_write_value[7:0]),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (rx_shift_reg),
        .pop       (rx_pop),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // STATUS word assembly
    always_comb begin
        status_word                     = '0;
        status_word[STATUS_TX_FULL]     = tx_full;
        status_word[STATUS_TX_EMPTY]    = tx_empty;
        status_word[STATUS_RX_AVAIL]    = !rx_empty;
        status_word[STATUS_RX_OVERRUN]  = overrun_reg;
        status_word[STATUS_TX_BUSY]     = (tx_state_reg != TX_IDLE) || !tx_empty;
        status_word[STATUS_FRAMING_ERR] = framing_reg;
    end

    // Read mux; uses pre-write state so write-during-read returns the old value
    always_comb begin
        read_value_next = '0;
        if (register_read) begin
            case (register_index)
                REG_UART_RX:     read_value_next = rx_empty ? 16'h0000 : {7'b0, 1'b1, rx_head};
                REG_UART_STATUS: read_value_next = status_word;
                REG_UART_BAUD:   read_value_next = baud_div_reg;
                default:         read_value_next = '0;
            endcase
        end
    end

    // Registered read data and writable bus state; a new error beats a clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_value_reg <= '0;
            baud_div_reg   <= 16'(DEFAULT_DIV);
            overrun_reg    <= 1'b0;
            framing_reg    <= 1'b0;
        end else begin
            read_value_reg <= read_value_next;
            if (register_write && (register_index == REG_UART_BAUD))
                baud_div_reg <= register_write_value;
            overrun_reg <= set_overrun ||
                           (overrun_reg && !(write_status && register_write_value[STATUS_RX_OVERRUN]));
            framing_reg <= set_framing ||
                           (framing_reg && !(write_status && register_write_value[STATUS_FRAMING_ERR]));
        end
    end

    assign register_read_value = read_value_reg;

    // ================= TX =================

    // TX state register
    always_ff @(posedge clk) begin
        if (!reset_n) tx_state_reg <= TX_IDLE;
        else          tx_state_reg <= tx_state_next;
    end

    // TX next state; a byte is popped whenever a new frame begins
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_state_next = TX_START;
                    tx_pop        = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == '0) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                if (tx_cnt_reg == '0 && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_cnt_reg == '0) begin
                    if (!tx_empty) begin
                        tx_state_next = TX_START;
                        tx_pop        = 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
        endcase
    end

    // TX bit timer and shifter; divisor is picked up at each reload
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
        end else if (tx_pop) begin
            tx_shift_reg <= tx_head;
            tx_cnt_reg   <= baud_div_reg;
            tx_bit_reg   <= '0;
        end else if (tx_state_reg != TX_IDLE) begin
            if (tx_cnt_reg == '0) begin
                tx_cnt_reg <= baud_div_reg;
                if (tx_state_reg == TX_DATA) begin
                    tx_shift_reg <= tx_shift_reg >> 1;
                    tx_bit_reg   <= tx_bit_reg + 3'd1;
                end
            end else begin
                tx_cnt_reg <= tx_cnt_reg - 16'd1;
            end
        end
    end

    // TX line level from state
    always_comb begin
        uart_tx = 1'b1;
        case (tx_state_reg)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift_reg[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    // ================= RX =================

    // Two-flop synchronizer plus previous-sample for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!reset_n) rx_state_reg <= RX_IDLE;
        else          rx_state_reg <= rx_state_next;
    end

    // RX next state; a start bit that reads high at mid-bit is a glitch
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt_reg == '0) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_cnt_reg == '0 && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            end
            RX_STOP: begin
                if (rx_cnt_reg == '0) rx_state_next = RX_IDLE;
            end
        endcase
    end

    // RX outputs at the stop-bit sample; a bus pop in the same cycle makes room
    always_comb begin
        rx_stop_sample = (rx_state_reg == RX_STOP) && (rx_cnt_reg == '0);
        rx_push        = rx_stop_sample && rx_sync_reg;
        set_overrun    = rx_stop_sample && rx_sync_reg && rx_full && !rx_pop;
        set_framing    = rx_stop_sample && !rx_sync_reg;
    end

    // RX sample timer and shifter; idle preloads the half-bit delay
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else if (rx_state_reg == RX_IDLE) begin
            rx_cnt_reg <= baud_div_reg >> 1;
            rx_bit_reg <= '0;
        end else if (rx_cnt_reg == '0) begin
            rx_cnt_reg <= baud_div_reg;
            if (rx_state_reg == RX_DATA) begin
                rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                rx_bit_reg   <= rx_bit_reg + 3'd1;
            end
        end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
        end
    end

endmodule
